sink_byte_packer: RTL and testbench
===================================

# sink_byte_packer

Serializes each output vector from the network sink stage into a stream of bytes for the host transmit path (UART/FIFO). Sits directly downstream of the sink stage and consumes its `snk_valid`/`snk_ready`/`snk` stream. Emits ceil(SNK_WIDTH/8) bytes per vector, least-significant chunk first, with an optional sequence-number header byte.

## Interface
- `SNK_WIDTH`, default `sink_config::SNK_WIDTH`, output vector width in bits (≥1).
- `SNK_BYTES`, default ceil(SNK_WIDTH/8), payload bytes per vector (derived; not overridden).
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `snk_valid`  in  1  upstream vector valid.
- `snk_ready`  out  1  packer can accept a vector.
- `snk`  in  SNK_WIDTH  upstream vector.
- `tx_valid`  out  1  `tx_data` valid.
- `tx_ready`  in  1  downstream accepts byte.
- `tx_data`  out  8  current byte.
- `tx_last`  out  1  high with final byte of a packet.

## Operation
- FSM states: IDLE, HDR (only with macro), SEND.
- IDLE: `snk_ready`=1, `tx_valid`=0. On `snk_valid && snk_ready`: capture `snk` zero-extended to 8*SNK_BYTES bits into shift register; byte index ← 0; go to HDR if macro enabled, else SEND.
- HDR: `tx_valid`=1, `tx_data`=seq counter, `tx_last`=0. On `tx_valid && tx_ready` → SEND.
- SEND: `tx_valid`=1, `tx_data`=shift register bits [7:0], `tx_last`=(index==SNK_BYTES-1). On handshake: shift right 8, index+1; if last → IDLE.
- Padding: bits above SNK_WIDTH in final byte are 0.
- `snk_ready` is high only in IDLE; upstream holds vector until accepted.
- Seq counter (8-bit, macro only): increments by 1 on handshake of the last byte; wraps 255→0.
- Index counter width: $clog2(SNK_BYTES+1); never exceeds SNK_BYTES-1 when in SEND.

## Timing
- Reset: `snk_ready`=0 during reset cycle, 1 the cycle after; `tx_valid`=0, `tx_last`=0, `tx_data`=0, seq=0, state IDLE.
- Latency: vector accepted at edge N; first byte (header or payload) valid in cycle N+1.
- Outputs are registered/state-decoded; no combinational path from `tx_ready` or `snk_valid` to any output.
- `tx_data`/`tx_last` stable while `tx_valid && !tx_ready`.
- Throughput with `tx_ready` held high: one byte per cycle; one bubble cycle (IDLE) between packets, i.e. SNK_BYTES+1 cycles per vector (+1 with header).
- Reset mid-packet: partial packet dropped, no further bytes; `tx_valid` low the cycle after `rst`; seq returns to 0.
- `rst` coincident with a handshake: reset wins; handshake ignored.

## Configuration
- `SINK_SEQ_HEADER_EN` defined: HDR state and 8-bit sequence counter compiled in; each packet is 1+SNK_BYTES bytes, header first.
- Undefined: no HDR state, no counter; packet is SNK_BYTES bytes; IDLE transitions directly to SEND.

## Structure
- `sink_config` package gains `SNK_BYTES` localparam and `snk_pack_state_t` enum (IDLE, HDR, SEND).
- Single module, no sub-modules; counter and shift register inline.

## Test plan
- SNK_WIDTH=12, `snk`=12'hABC, `tx_ready`=1, macro off -> bytes 8'hBC (`tx_last`=0), 8'h0A (`tx_last`=1); `snk_ready` returns high next cycle.
- SNK_WIDTH=8, three back-to-back vectors 8'h01,8'h02,8'h03 -> each 1-byte packet with `tx_last`=1, 2 cycles per vector.
- Backpressure: `tx_ready` low 5 cycles during byte 0 of 12'hABC -> `tx_data` holds 8'hBC, `snk_ready` stays 0, no bytes lost.
- Macro on, 257 vectors of 12'h000 -> headers 0..255 then 0 again; every packet 3 bytes.
- Assert `rst` after first byte of 12'hABC -> 8'h0A never emitted; `tx_valid`=0 next cycle; next vector starts fresh at byte 0 (seq 0 with macro).
- `snk_valid` held high with 12'hFFF while `tx_ready` toggles randomly -> byte stream FF,0F repeated, padding bits always 0.

Source files
------------

// File: rtl/sink_config_pkg.sv
// sink_config: shared widths and the byte-packer FSM state type for the network sink path.
package sink_config;

  localparam int SNK_WIDTH = 12;
  localparam int SNK_BYTES = (SNK_WIDTH + 7) / 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HDR  = 2'd1,
    SEND = 2'd2
  } snk_pack_state_t;

endpackage

// File: rtl/sink_byte_packer.sv
// sink_byte_packer: serializes each sink vector into bytes, least-significant byte first.
// Define SINK_SEQ_HEADER_EN to prepend an 8-bit sequence-number header byte to every packet.
module sink_byte_packer #(
  parameter int SNK_WIDTH = sink_config::SNK_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 snk_valid,
  output logic                 snk_ready,
  input  logic [SNK_WIDTH-1:0] snk,
  output logic                 tx_valid,
  input  logic                 tx_ready,
  output logic [7:0]           tx_data,
  output logic                 tx_last
);
  import sink_config::snk_pack_state_t;
  import sink_config::IDLE;
  import sink_config::HDR;
  import sink_config::SEND;

  localparam int SNK_BYTES = (SNK_WIDTH + 7) / 8;
  localparam int SHW       = 8 * SNK_BYTES;
  localparam int IDX_W     = $clog2(SNK_BYTES + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SNK_BYTES - 1);

  snk_pack_state_t  state;
  logic [SHW-1:0]   shreg;
  logic [IDX_W-1:0] idx;
  logic             is_last;
`ifdef SINK_SEQ_HEADER_EN
  logic [7:0]       seq;
`endif

  assign is_last = (idx == LAST_IDX);

  // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      idx   <= '0;
`ifdef SINK_SEQ_HEADER_EN
      seq   <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (snk_valid) begin
            // Size cast zero-extends, so padding above SNK_WIDTH is always 0.
            shreg <= SHW'(snk);
            idx   <= '0;
`ifdef SINK_SEQ_HEADER_EN
            state <= HDR;
`else
            state <= SEND;
`endif
          end
        end
`ifdef SINK_SEQ_HEADER_EN
        HDR: begin
          if (tx_ready) state <= SEND;
        end
`endif
        SEND: begin
          if (tx_ready) begin
            shreg <= shreg >> 8;
            if (is_last) begin
              idx   <= '0;
              state <= IDLE;
`ifdef SINK_SEQ_HEADER_EN
              seq   <= seq + 8'd1;
`endif
            end else begin
              idx <= idx + IDX_W'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // NOTE: shreg has no reset; its contents are only observed while in SEND, after a capture.

  // Reset gates snk_ready directly so a handshake coincident with rst is never seen upstream.
  assign snk_ready = (state == IDLE) && !rst;

  // NOTE: every always_comb output gets a default first, so no path infers a latch.
  always_comb begin
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    tx_last  = 1'b0;
    case (state)
`ifdef SINK_SEQ_HEADER_EN
      HDR: begin
        tx_valid = 1'b1;
        tx_data  = seq;
      end
`endif
      SEND: begin
        tx_valid = 1'b1;
        tx_data  = shreg[7:0];
        tx_last  = is_last;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_sink_byte_packer.sv
// tb_sink_byte_packer: directed checks of sink_byte_packer at SNK_WIDTH=12 and SNK_WIDTH=8.
// Header expectations follow SINK_SEQ_HEADER_EN when it is defined for the build.
module tb_sink_byte_packer;

  logic        clk = 1'b0;
  logic        rst12, rst8;
  logic        snk_valid12, snk_valid8;
  logic        snk_ready12, snk_ready8;
  logic [11:0] snk12;
  logic [7:0]  snk8;
  logic        tx_valid12, tx_valid8;
  logic        tx_ready12, tx_ready8;
  logic [7:0]  tx_data12, tx_data8;
  logic        tx_last12, tx_last8;

  int checks   = 0;
  int failures = 0;

`ifdef SINK_SEQ_HEADER_EN
  logic [7:0] exp_seq12 = 8'd0;
  logic [7:0] exp_seq8  = 8'd0;
  localparam int PKT12 = 3;
`else
  localparam int PKT12 = 2;
`endif

  always #5 clk = ~clk;

  sink_byte_packer #(.SNK_WIDTH(12)) u_dut12 (
    .clk(clk), .rst(rst12),
    .snk_valid(snk_valid12), .snk_ready(snk_ready12), .snk(snk12),
    .tx_valid(tx_valid12), .tx_ready(tx_ready12), .tx_data(tx_data12), .tx_last(tx_last12)
  );

  sink_byte_packer #(.SNK_WIDTH(8)) u_dut8 (
    .clk(clk), .rst(rst8),
    .snk_valid(snk_valid8), .snk_ready(snk_ready8), .snk(snk8),
    .tx_valid(tx_valid8), .tx_ready(tx_ready8), .tx_data(tx_data8), .tx_last(tx_last8)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Expects a valid byte on the 12-bit instance now, then advances one cycle.
  task automatic recv12(input string tag, input logic [7:0] d, input logic last);
    check({tag, "_v"}, 32'(tx_valid12), 32'd1);
    check({tag, "_d"}, 32'({tx_last12, tx_data12}), 32'({last, d}));
    @(negedge clk);
  endtask

  // Presents one vector for one cycle on the 12-bit instance; consumes the header if built in.
  task automatic accept12(input string tag, input logic [11:0] v);
    check({tag, "_rdy"}, 32'(snk_ready12), 32'd1);
    snk12       = v;
    snk_valid12 = 1'b1;
    @(negedge clk);
    snk_valid12 = 1'b0;
`ifdef SINK_SEQ_HEADER_EN
    recv12({tag, "_hdr"}, exp_seq12, 1'b0);
    exp_seq12 = exp_seq12 + 8'd1;
`endif
  endtask

  initial begin
    rst12 = 1'b1; rst8 = 1'b1;
    snk_valid12 = 1'b0; snk_valid8 = 1'b0;
    tx_ready12  = 1'b1; tx_ready8  = 1'b1;
    snk12 = '0; snk8 = '0;

    // Reset state
    @(negedge clk); @(negedge clk);
    check("t1_rdy_in_rst", 32'(snk_ready12), 32'd0);
    check("t1_valid_rst",  32'(tx_valid12),  32'd0);
    rst12 = 1'b0; rst8 = 1'b0;
    @(negedge clk);
    check("t1_rdy_after", 32'(snk_ready12), 32'd1);
    check("t1_out_idle",  32'({tx_valid12, tx_last12, tx_data12}), 32'd0);
    check("t1_rdy8",      32'(snk_ready8), 32'd1);

    // 12'hABC, tx_ready high
    accept12("t2", 12'hABC);
    check("t2_rdy_busy", 32'(snk_ready12), 32'd0);
    recv12("t2_b0", 8'hBC, 1'b0);
    recv12("t2_b1", 8'h0A, 1'b1);
    check("t2_rdy_back", 32'(snk_ready12), 32'd1);
    check("t2_idle_v",   32'(tx_valid12),  32'd0);

    // SNK_WIDTH=8, three back-to-back vectors with snk_valid held high
    snk_valid8 = 1'b1;
    for (int v = 1; v <= 3; v++) begin
      check("t3_rdy", 32'(snk_ready8), 32'd1);
      snk8 = v[7:0];
      @(negedge clk);
`ifdef SINK_SEQ_HEADER_EN
      check("t3_hdr", 32'({tx_valid8, tx_last8, tx_data8}), 32'({2'b10, exp_seq8}));
      exp_seq8 = exp_seq8 + 8'd1;
      @(negedge clk);
`endif
      check("t3_byte", 32'({tx_valid8, tx_last8, tx_data8}), 32'({2'b11, v[7:0]}));
      check("t3_busy", 32'(snk_ready8), 32'd0);
      @(negedge clk);
    end
    snk_valid8 = 1'b0;
    check("t3_idle", 32'(tx_valid8), 32'd0);

    // Backpressure on byte 0
    accept12("t4", 12'hABC);
    tx_ready12 = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("t4_hold_d",   32'({tx_valid12, tx_last12, tx_data12}), 32'({2'b10, 8'hBC}));
      check("t4_hold_rdy", 32'(snk_ready12), 32'd0);
      @(negedge clk);
    end
    tx_ready12 = 1'b1;
    recv12("t4_b0", 8'hBC, 1'b0);
    recv12("t4_b1", 8'h0A, 1'b1);
    check("t4_idle", 32'(tx_valid12), 32'd0);

    // Reset mid-packet, coincident with the handshake of byte 1
    accept12("t5", 12'hABC);
    recv12("t5_b0", 8'hBC, 1'b0);
    rst12 = 1'b1;
    @(negedge clk);
    check("t5_v_after_rst",   32'(tx_valid12),  32'd0);
    check("t5_rdy_during_rst", 32'(snk_ready12), 32'd0);
    rst12 = 1'b0;
`ifdef SINK_SEQ_HEADER_EN
    exp_seq12 = 8'd0;
`endif
    @(negedge clk);
    check("t5_no_stale", 32'(tx_valid12), 32'd0);
    accept12("t5n", 12'h5A3);
    recv12("t5n_b0", 8'hA3, 1'b0);
    recv12("t5n_b1", 8'h05, 1'b1);

`ifdef SINK_SEQ_HEADER_EN
    // Sequence counter wrap across 257 packets
    for (int i = 0; i < 257; i++) begin
      accept12("t7", 12'h000);
      recv12("t7_b0", 8'h00, 1'b0);
      recv12("t7_b1", 8'h00, 1'b1);
    end
`endif

    // 12'hFFF held valid while tx_ready toggles
    begin
      int pos  = 0;
      int got  = 0;
      int cyc  = 0;
      logic [8:0] exp;
      snk12       = 12'hFFF;
      snk_valid12 = 1'b1;
      while (got < 30 && cyc < 600) begin
        tx_ready12 = 1'($urandom_range(0, 1));
        if (tx_valid12 && tx_ready12) begin
`ifdef SINK_SEQ_HEADER_EN
          if (pos == 0) exp = {1'b0, exp_seq12};
          else
`endif
          exp = (pos == PKT12 - 1) ? {1'b1, 8'h0F} : {1'b0, 8'hFF};
          check("t6_stream", 32'({tx_last12, tx_data12}), 32'(exp));
          got++;
          if (pos == PKT12 - 1) begin
            pos = 0;
`ifdef SINK_SEQ_HEADER_EN
            exp_seq12 = exp_seq12 + 8'd1;
`endif
          end else begin
            pos++;
          end
        end
        @(negedge clk);
        cyc++;
      end
      check("t6_byte_count", 32'(got), 32'd30);
      snk_valid12 = 1'b0;
      tx_ready12  = 1'b1;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
